muldiv_seq: RTL and testbench

MULDIV_SEQ -- requirements
Module: muldiv_seq

---
 rtl/muldiv_pkg.sv | 36 +++
 rtl/muldiv_step.sv | 41 ++++
 rtl/muldiv_seq.sv | 136 +++++++++++++
 tb/tb_muldiv_seq.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the sequential RV32M multiply/divide unit.
// Divider datapath is built only when MULDIV_DIV_EN is defined.
package muldiv_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIX,
      DONE
   } state_t;

   localparam logic [2:0] OP_MUL    = 3'b000;
   localparam logic [2:0] OP_MULH   = 3'b001;
   localparam logic [2:0] OP_MULHSU = 3'b010;
   localparam logic [2:0] OP_MULHU  = 3'b011;
   localparam logic [2:0] OP_DIV    = 3'b100;
   localparam logic [2:0] OP_DIVU   = 3'b101;
   localparam logic [2:0] OP_REM    = 3'b110;
   localparam logic [2:0] OP_REMU   = 3'b111;

   localparam int ITERS = 32;

   // {rs1 signed, rs2 signed}
   function automatic logic [1:0] op_sign(input logic [2:0] f);
      logic [1:0] s;
      s = 2'b00;
      unique case (f)
         OP_MUL, OP_MULH, OP_DIV, OP_REM: s = 2'b11;
         OP_MULHSU:                       s = 2'b10;
         OP_MULHU, OP_DIVU, OP_REMU:      s = 2'b00;
         default:                         s = 2'b00;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply or restoring shift-subtract divide.
// The divide path exists only when MULDIV_DIV_EN is defined.
module muldiv_step
   import muldiv_pkg::*;
#(
   parameter int W = 32
) (
`ifdef MULDIV_DIV_EN
   input  logic         is_div,
`endif
   input  logic [W-1:0] hi,
   input  logic [W-1:0] lo,
   input  logic [W-1:0] b,
   output logic [W-1:0] hi_nxt,
   output logic [W-1:0] lo_nxt
);

   logic [W:0] sum;
`ifdef MULDIV_DIV_EN
   logic [W:0]   sh;
   logic [W-1:0] sub;
   logic         ge;
`endif

   always_comb begin
      sum    = {1'b0, hi} + (lo[0] ? {1'b0, b} : '0);
      hi_nxt = sum[W:1];
      lo_nxt = {sum[0], lo[W-1:1]};
`ifdef MULDIV_DIV_EN
      // remainder is always below the divisor, so W bits hold the difference
      sh  = {hi, lo[W-1]};
      ge  = sh >= {1'b0, b};
      sub = sh[W-1:0] - b;
      if (is_div) begin
         hi_nxt = ge ? sub : sh[W-1:0];
         lo_nxt = {lo[W-2:0], ge};
      end
`endif
   end

endmodule

// File: rtl/muldiv_seq.sv
// Sequential RV32M multiply/divide unit, 32 iterations plus sign fix-up.
// Define MULDIV_DIV_EN to build the divider; otherwise divides return 0.
module muldiv_seq
   import muldiv_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [2:0]            funct3,
   input  logic [DATA_WIDTH-1:0] SrcA,
   input  logic [DATA_WIDTH-1:0] SrcB,
   input  logic                  flush,
   output logic                  resp_valid,
   output logic [DATA_WIDTH-1:0] Result
);

   localparam int W = DATA_WIDTH;
   localparam logic [W-1:0] MIN = {1'b1, {(W-1){1'b0}}};
   localparam logic [4:0] LAST = 5'(ITERS - 1);

   state_t state, state_nxt;

   logic [2:0]     op;
   logic [W-1:0]   opb, hi, lo;
   logic [W-1:0]   hi_nxt, lo_nxt;
   logic [4:0]     cnt;
   logic           neg;

   logic [1:0]     sg;
   logic           sa, sb, neg_in;
   logic [W-1:0]   amag, bmag;
   logic           bypass, accept;
   logic [W-1:0]   byp_res;

   logic [2*W-1:0] prod, prod_s;
   logic [W-1:0]   mul_res, div_res, fix_res;

   assign req_ready  = (state == IDLE);
   assign resp_valid = (state == DONE);
   assign accept     = req_valid && req_ready && !flush;

   always_comb begin
      sg      = op_sign(funct3);
      sa      = sg[1] & SrcA[W-1];
      sb      = sg[0] & SrcB[W-1];
      amag    = sa ? -SrcA : SrcA;
      bmag    = sb ? -SrcB : SrcB;
      // remainder follows the dividend, everything else follows signA^signB
      neg_in  = (funct3[2] & funct3[1]) ? sa : (sa ^ sb);
      bypass  = 1'b0;
      byp_res = '0;
`ifdef MULDIV_DIV_EN
      if (funct3[2] && SrcB == '0) begin
         bypass  = 1'b1;
         byp_res = funct3[1] ? SrcA : '1;
      end else if (funct3[2] && !funct3[0] &&
                   SrcA == MIN && SrcB == '1) begin
         bypass  = 1'b1;
         byp_res = funct3[1] ? '0 : MIN;
      end
`else
      bypass  = funct3[2];
`endif
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: if (accept) state_nxt = bypass ? DONE : CALC;
         CALC: if (cnt == LAST) state_nxt = FIX;
         FIX:  state_nxt = DONE;
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (flush) state_nxt = IDLE;
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   muldiv_step #(.W(W)) u_step (
`ifdef MULDIV_DIV_EN
      .is_div (op[2]),
`endif
      .hi     (hi),
      .lo     (lo),
      .b      (opb),
      .hi_nxt (hi_nxt),
      .lo_nxt (lo_nxt)
   );

   always_comb begin
      prod    = {hi, lo};
      prod_s  = neg ? -prod : prod;
      mul_res = (op[1:0] == 2'b00) ? prod_s[W-1:0] : prod_s[2*W-1:W];
`ifdef MULDIV_DIV_EN
      if (op[1]) div_res = neg ? -hi : hi;
      else       div_res = neg ? -lo : lo;
`else
      div_res = '0;
`endif
      fix_res = op[2] ? div_res : mul_res;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         op     <= '0;
         opb    <= '0;
         hi     <= '0;
         lo     <= '0;
         cnt    <= '0;
         neg    <= 1'b0;
         Result <= '0;
      end else if (accept) begin
         op  <= funct3;
         opb <= bmag;
         hi  <= '0;
         lo  <= amag;
         cnt <= '0;
         neg <= neg_in;
         if (bypass) Result <= byp_res;
      end else if (state == CALC && !flush) begin
         hi  <= hi_nxt;
         lo  <= lo_nxt;
         cnt <= cnt + 5'd1;
      end else if (state == FIX && !flush) begin
         Result <= fix_res;
      end
   end

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: directed vectors, queue-based monitor.
// Divide expectations follow whether MULDIV_DIV_EN is defined.
module tb_muldiv_seq;
   import muldiv_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [2:0]  funct3 = 3'b000;
   logic [31:0] SrcA = '0;
   logic [31:0] SrcB = '0;
   logic        flush = 1'b0;
   logic        resp_valid;
   logic [31:0] Result;

   typedef struct {
      string       nm;
      logic [31:0] res;
      int          acc;
      int          lat;
   } exp_t;

   exp_t        q[$];
   exp_t        me;
   int          cyc = 0;
   int          nvec = 0;
   int          nfail = 0;
   logic [31:0] last_res = '0;

   muldiv_seq #(.DATA_WIDTH(32)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .funct3     (funct3),
      .SrcA       (SrcA),
      .SrcB       (SrcB),
      .flush      (flush),
      .resp_valid (resp_valid),
      .Result     (Result)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      #1;
      if (resp_valid === 1'b1) begin
         nvec++;
         if (q.size() == 0) begin
            nfail++;
            $display("FAIL spurious_resp got=%h required=no response",
                     Result);
         end else begin
            me = q.pop_front();
            if (Result !== me.res || (cyc - me.acc + 1) != me.lat) begin
               nfail++;
               $display("FAIL %s got=%h lat=%0d required=%h lat=%0d",
                        me.nm, Result, cyc - me.acc + 1, me.res, me.lat);
            end
         end
      end
   end

   task automatic check(input string nm, input logic [31:0] got,
                        input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nfail++;
         $display("FAIL %s got=%h required=%h", nm, got, exp);
      end
   endtask

   task automatic issue(input string nm, input logic [2:0] f,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] res, input int lat,
                        input bit chk);
      int n;
      n = 0;
      @(negedge clk);
      while (req_ready !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (req_ready !== 1'b1) begin
         nvec++;
         nfail++;
         $display("FAIL %s_ready_timeout got=0 required=1", nm);
      end else begin
         req_valid = 1'b1;
         funct3    = f;
         SrcA      = a;
         SrcB      = b;
         if (chk) begin
            q.push_back('{nm, res, cyc + 1, lat});
            last_res = res;
         end
         @(negedge clk);
         req_valid = 1'b0;
         funct3    = ~f;
         SrcA      = $urandom;
         SrcB      = $urandom;
      end
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (q.size() != 0) begin
         nvec++;
         nfail++;
         $display("FAIL resp_timeout got=%0d pending required=0",
                  q.size());
         q.delete();
      end
   endtask

   initial begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      check("reset_ready", {31'd0, req_ready}, 32'd1);
      check("reset_resp", {31'd0, resp_valid}, 32'd0);
      check("reset_result", Result, 32'd0);

      issue("mul_7_m3", OP_MUL, 32'd7, 32'hFFFF_FFFD,
            32'hFFFF_FFEB, 34, 1);
      issue("mulhu_max", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
            32'hFFFF_FFFE, 34, 1);
      issue("mulh_m1", OP_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
            32'h0000_0000, 34, 1);
      issue("mulhsu_m1", OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
            32'hFFFF_FFFF, 34, 1);
      issue("mul_shift", OP_MUL, 32'h1234_5678, 32'h0000_0010,
            32'h2345_6780, 34, 1);
      issue("mulh_min", OP_MULH, 32'h8000_0000, 32'h8000_0000,
            32'h4000_0000, 34, 1);
`ifdef MULDIV_DIV_EN
      issue("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2,
            32'hFFFF_FFFD, 34, 1);
      issue("rem_m7_2", OP_REM, 32'hFFFF_FFF9, 32'd2,
            32'hFFFF_FFFF, 34, 1);
      issue("div_7_m2", OP_DIV, 32'd7, 32'hFFFF_FFFE,
            32'hFFFF_FFFD, 34, 1);
      issue("rem_7_m2", OP_REM, 32'd7, 32'hFFFF_FFFE,
            32'd1, 34, 1);
      issue("remu_100_7", OP_REMU, 32'd100, 32'd7, 32'd2, 34, 1);
      issue("divu_5_0", OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 1);
      issue("rem_9_0", OP_REM, 32'd9, 32'd0, 32'd9, 1, 1);
      issue("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
            32'h8000_0000, 1, 1);
      issue("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF,
            32'd0, 1, 1);
`else
      issue("div_nodiv", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'd0, 1, 1);
      issue("remu_nodiv", OP_REMU, 32'd9, 32'd4, 32'd0, 1, 1);
      issue("divu0_nodiv", OP_DIVU, 32'd5, 32'd0, 32'd0, 1, 1);
`endif
      issue("mul_b2b", OP_MUL, 32'd3, 32'd5, 32'd15, 34, 1);
      wait_done();
      @(negedge clk);
      check("b2b_ready", {31'd0, req_ready}, 32'd1);
      repeat (3) @(negedge clk);
      check("result_hold", Result, last_res);

      req_valid = 1'b1;
      flush     = 1'b1;
      funct3    = OP_MUL;
      @(negedge clk);
      check("flush_blocks_req", {31'd0, req_ready}, 32'd1);
      req_valid = 1'b0;
      flush     = 1'b0;

      issue("mul_flushed", OP_MUL, 32'd3, 32'd5, 32'd0, 0, 0);
      repeat (8) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("flush_idle", {31'd0, req_ready}, 32'd1);
      check("flush_result", Result, last_res);
`ifdef MULDIV_DIV_EN
      issue("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14, 34, 1);
`else
      issue("divu_nodiv", OP_DIVU, 32'd100, 32'd7, 32'd0, 1, 1);
`endif
      wait_done();

`ifdef MULDIV_DIV_EN
      issue("div_reset", OP_DIV, 32'd100, 32'd7, 32'd0, 0, 0);
`else
      issue("mul_reset", OP_MUL, 32'd100, 32'd7, 32'd0, 0, 0);
`endif
      repeat (18) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("rst_mid_result", Result, 32'd0);
      check("rst_mid_resp", {31'd0, resp_valid}, 32'd0);
      check("rst_mid_ready", {31'd0, req_ready}, 32'd1);

      issue("mul_after_rst", OP_MUL, 32'd6, 32'd7, 32'd42, 34, 1);
      wait_done();
      repeat (40) @(negedge clk);
      check("final_hold", Result, last_res);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
